bcd_sv_ff: RTL and testbench

- Sequential 14-bit binary to 4-digit decimal converter with ASCII output.
- It is used by the sensor crossbar to turn DHT11 temperature/moisture bytes and HC-SR04 distance words into printable characters for the UART.
- Conversion runs as iterative double-dabble (shift-and-add-3), one bit per clock, under a level request / level ready handshake.

---
 rtl/bcd_sv_ff.sv | 105 ++++++++++
 tb/tb_bcd_sv_ff.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bcd_sv_ff.sv
// Sequential 14-bit binary to 4-digit ASCII decimal converter (iterative double-dabble).
// Optional build macro BCD_LEADING_BLANK_EN: leading zero digits are emitted as ASCII space.
module bcd_sv_ff #(
  parameter int IN_W    = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] bin_in,
  input  logic            cross_ready,
  output logic [31:0]     ascii_out,
  output logic            bcd_ready
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [IN_W-1:0] shift_reg;
  logic [15:0]     bcd;
  logic [3:0]      cnt;

  logic [IN_W-1:0]  sat_in;
  logic [15:0]      adj;
  logic [IN_W+15:0] shifted;
  logic [15:0]      bcd_next;
  logic [IN_W-1:0]  shift_next;

  always_comb begin
    sat_in = (bin_in > IN_W'(MAX_VAL)) ? IN_W'(MAX_VAL) : bin_in;
  end

  // Add-3 correction on every nibble before the shift.
  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
  end

  always_comb begin
    shifted    = {adj, shift_reg} << 1;
    bcd_next   = shifted[IN_W+15:IN_W];
    shift_next = shifted[IN_W-1:0];
  end

  function automatic logic [31:0] to_ascii(input logic [15:0] d);
    logic [31:0] a;
    a = {4'h3, d[15:12], 4'h3, d[11:8], 4'h3, d[7:4], 4'h3, d[3:0]};
`ifdef BCD_LEADING_BLANK_EN
    if (d[15:12] == 4'd0) begin
      a[31:24] = 8'h20;
      if (d[11:8] == 4'd0) begin
        a[23:16] = 8'h20;
        if (d[7:4] == 4'd0) a[15:8] = 8'h20;
      end
    end
`endif
    return a;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bcd       <= '0;
      cnt       <= '0;
      ascii_out <= 32'h30303030;
      bcd_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bcd_ready <= 1'b0;
          if (cross_ready) begin
            shift_reg <= sat_in;
            bcd       <= '0;
            cnt       <= 4'(IN_W);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          bcd       <= bcd_next;
          shift_reg <= shift_next;
          cnt       <= cnt - 4'd1;
          // Final iteration publishes the result from the post-shift value in the same edge.
          if (cnt == 4'd1) begin
            ascii_out <= to_ascii(bcd_next);
            bcd_ready <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (!cross_ready) begin
            bcd_ready <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          bcd_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sv_ff.sv
// Scoreboard bench for bcd_sv_ff: stimulus pushes expected ASCII from an arithmetic model,
// a negedge monitor pops and compares on each bcd_ready rise.
module tb_bcd_sv_ff;

  logic        clk = 1'b0;
  logic        rst;
  logic        cross_ready;
  logic [13:0] bin_in;
  logic [31:0] ascii_out;
  logic        bcd_ready;

  bcd_sv_ff #(.IN_W(14), .MAX_VAL(9999)) dut (
    .clk        (clk),
    .rst        (rst),
    .bin_in     (bin_in),
    .cross_ready(cross_ready),
    .ascii_out  (ascii_out),
    .bcd_ready  (bcd_ready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  logic        rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  typedef struct {
    logic [31:0] ascii;
    int unsigned accept;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Decimal digits by plain division, then ASCII encoding.
  function automatic logic [31:0] model(input int unsigned val);
    int unsigned v;
    int unsigned d[4];
    logic [31:0] a;
    v    = (val > 9999) ? 9999 : val;
    d[3] = v / 1000;
    d[2] = (v / 100) % 10;
    d[1] = (v / 10) % 10;
    d[0] = v % 10;
    for (int k = 0; k < 4; k++) a[8*k +: 8] = 8'(8'h30 + d[k]);
`ifdef BCD_LEADING_BLANK_EN
    for (int k = 3; k >= 1; k--) begin
      if (d[k] != 0) break;
      a[8*k +: 8] = 8'h20;
    end
`endif
    return a;
  endfunction

  logic [31:0] last_exp   = 32'h30303030;
  logic        prev_ready = 1'b0;
  exp_t        e;

  always @(negedge clk) begin
    if (rst_seen) begin
      check("reset_ready", {31'b0, bcd_ready}, 32'd0);
      check("reset_ascii", ascii_out, 32'h30303030);
      last_exp   = 32'h30303030;
      prev_ready = 1'b0;
    end else begin
      if (bcd_ready && !prev_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", {31'b0, bcd_ready}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ascii", ascii_out, e.ascii);
          // Edges counted inclusively from the accepting edge to the DONE-entry edge.
          check("latency", cyc - e.accept + 1, 32'd15);
          last_exp = e.ascii;
        end
      end else begin
        check("ascii_hold", ascii_out, last_exp);
      end
      prev_ready = bcd_ready;
    end
  end

  // mode 0: hold request; 1: one-clock pulse; 2: hold and change bin_in during SHIFT
  task automatic run_conv(input int unsigned val, input int unsigned mode, input int unsigned hold);
    int unsigned t;
    @(negedge clk);
    bin_in      = 14'(val);
    cross_ready = 1'b1;
    sb.push_back('{model(val), cyc + 1});
    if (mode == 1) begin
      @(negedge clk);
      cross_ready = 1'b0;
      bin_in      = 14'($urandom);
    end else if (mode == 2) begin
      repeat (3) @(negedge clk);
      bin_in = 14'($urandom);
    end
    t = 0;
    while (!bcd_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bcd_ready) check("ready_timeout", {31'b0, bcd_ready}, 32'd1);
    if (mode == 1) begin
      @(negedge clk);
      check("pulse_one_cycle", {31'b0, bcd_ready}, 32'd0);
    end else begin
      repeat (hold) begin
        @(negedge clk);
        check("ready_held", {31'b0, bcd_ready}, 32'd1);
      end
      cross_ready = 1'b0;
      @(negedge clk);
      check("ready_drop", {31'b0, bcd_ready}, 32'd0);
    end
  endtask

  task automatic reset_mid_shift();
    @(negedge clk);
    bin_in      = 14'd4321;
    cross_ready = 1'b1;
    repeat (6) @(negedge clk);
    rst         = 1'b1;
    cross_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    cross_ready = 1'b0;
    bin_in      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_conv(25, 0, 3);
    run_conv(0, 0, 1);
    run_conv(9999, 0, 1);
    run_conv(16383, 0, 0);
    run_conv(10000, 0, 0);
    run_conv(7, 0, 0);
    run_conv(1234, 2, 2);
    run_conv(100, 1, 0);
    reset_mid_shift();
    run_conv(25, 0, 1);
    run_conv(42, 1, 0);

    for (int i = 0; i < 30; i++) begin
      int unsigned v;
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(10000, 16383) : $urandom_range(0, 9999);
      run_conv(v, $urandom_range(0, 2), $urandom_range(0, 4));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
